regfile_access_arbiter: RTL and testbench
=========================================

Name: regfile_access_arbiter

Overview:
- Sequences and shares the single-write-port register file between two requesters: requester 0 is the core datapath and requester 1 is the debug/load port.
- Each request is a two-operand read or a one-register write. A round-robin FSM latches one request at a time and drives the register file's address, data, reg_dest and reg_write inputs.
- It generates a one-cycle reg_write strobe, after stable addresses, that the register file needs from its controller. It captures read data and returns it with a one-cycle ack.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- PROTECT_R0, 1, when 1 a write to register 0 is suppressed and flagged as an error.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  2  request per requester (bit i = requester i); held high until ack[i].
- req_we  in  2  per requester: 1 = write, 0 = read.
- req_ra  in  2*ADDR_W  read address A; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_rb  in  2*ADDR_W  read address B, same packing.
- req_wa  in  2*ADDR_W  write address, same packing.
- req_wdat  in  2*DATA_W  write data, packed the same way.
- ack  out  2  one-cycle completion pulse to the served requester.
- rsp_rdat1  out  DATA_W  captured rf[ra]; valid with ack and held until the next capture.
- rsp_rdat2  out  DATA_W  captured rf[rb]; valid with ack and held until the next capture.
- rsp_err  out  1  high with ack when a write to r0 was suppressed.
- busy  out  1  high in any state other than IDLE.
- rf_reg1  out  ADDR_W  register file read register 1.
- rf_reg2  out  ADDR_W  register file read register 2.
- rf_reg3  out  ADDR_W  register file write register when rf_reg_dest = 1.
- rf_wdat  out  DATA_W  register file write data.
- rf_reg_dest  out  1  selects rf_reg3 as the write register.
- rf_reg_write  out  1  write strobe.
- rf_rdat1  in  DATA_W  register file read data 1.
- rf_rdat2  in  DATA_W  register file read data 2.

Behaviour:
- Reset values:
  - State IDLE, last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0, including rsp_rdat1/2; rf_reg_write is forced 0 asynchronously.
- All rf_* outputs and ack are registered, with no combinational path from req.
- FSM states: IDLE, SETUP, WSTROBE, CAPT, DONE.
- IDLE:
  - Only one req bit set: grant that requester.
  - Both set: grant the requester not equal to last_grant.
  - Latch the granted we, ra, rb, wa and wdat into internal registers, then go to SETUP.
  - With no req, stay in IDLE.
- SETUP (reg_write = 0):
  - Read: rf_reg1 = ra, rf_reg2 = rb, rf_reg_dest = 0.
  - Write: rf_reg3 = wa, rf_reg2 = 0, rf_wdat = wdat, rf_reg_dest = 1.
  - Next state: WSTROBE if write, else CAPT.
- WSTROBE:
  - rf_reg_write = 1 for exactly this cycle, with addresses and data unchanged.
  - If PROTECT_R0 = 1 and wa = 0, rf_reg_write stays 0 and err is set.
  - Next state: DONE.
- CAPT:
  - rsp_rdat1 <= rf_rdat1 and rsp_rdat2 <= rf_rdat2 at the end of this cycle.
  - Next state: DONE.
- DONE:
  - ack[granted] = 1 and rsp_err = err for one cycle.
  - last_grant <= granted; clear err; next state IDLE.
  - rf_reg_dest returns to 0 and rf_reg_write stays 0.
- Latency: if req is sampled in IDLE at edge N, ack is high during the cycle after edge N+3. Throughput is one transaction per 4 cycles.
- Write data visibility: a read granted after a write's ack returns the written value.
- req dropped before ack: the latched transaction still completes and is acked.
- req still high in the cycle after ack: treated as a new transaction. Under contention this request loses to the other requester.
- Request fields changing after grant have no effect.
- Both requesters requesting continuously: grants strictly alternate.
- Reset mid-operation:
  - The transaction is aborted and no ack is issued.
  - A write whose strobe has not yet occurred is not performed.
- rsp_rdat1/2 are unchanged by write transactions.

Test Plan:
- Reset, then req = 01 write wa = 8, wdat = 0xDEADBEEF. Expect rf_reg_write high for exactly 1 cycle with rf_reg_dest = 1 and rf_reg3 = 8. Expect ack = 01 three cycles after grant, rsp_err = 0.
- After the write above, req = 10 read ra = 8, rb = 9 (r9 = 0). Expect rsp_rdat1 = 0xDEADBEEF, rsp_rdat2 = 0, with ack = 10.
- Hold req = 11 with reads for 4 transactions. Expect ack sequence 01, 10, 01, 10, and rf_reg_write never asserted.
- Write wa = 0, wdat = 0x1234 with PROTECT_R0 = 1. Expect rf_reg_write to stay 0, ack with rsp_err = 1, and a subsequent read of r0 unchanged.
- Assert reset during SETUP of a write to r16. Expect all outputs 0 immediately, no ack, and a later read of r16 returns its prior value.
- Drop req the cycle after grant on a read of r10. Expect the transaction still to complete, ack pulsed, and rsp_rdat1 = rf[10].

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin sequencer sharing one register file between the core datapath and the debug/load port.
module regfile_access_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_ra,
    input  logic [2*ADDR_W-1:0] req_rb,
    input  logic [2*ADDR_W-1:0] req_wa,
    input  logic [2*DATA_W-1:0] req_wdat,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rsp_rdat1,
    output logic [DATA_W-1:0]   rsp_rdat2,
    output logic                rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   rf_reg1,
    output logic [ADDR_W-1:0]   rf_reg2,
    output logic [ADDR_W-1:0]   rf_reg3,
    output logic [DATA_W-1:0]   rf_wdat,
    output logic                rf_reg_dest,
    output logic                rf_reg_write,
    input  logic [DATA_W-1:0]   rf_rdat1,
    input  logic [DATA_W-1:0]   rf_rdat2
);
    typedef enum logic [2:0] {IDLE, SETUP, WSTROBE, CAPT, DONE} state_t;
    state_t              state;
    logic                last_grant, grant, g_we, err, pick, r0_block;
    logic [ADDR_W-1:0]   g_ra, g_rb, g_wa;
    logic [DATA_W-1:0]   g_wdat;
    assign pick     = (req == 2'b11) ? ~last_grant : req[1];
    assign r0_block = PROTECT_R0 && (g_wa == '0);
    assign busy     = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            g_we         <= 1'b0;
            g_ra         <= '0;
            g_rb         <= '0;
            g_wa         <= '0;
            g_wdat       <= '0;
            err          <= 1'b0;
            ack          <= '0;
            rsp_rdat1    <= '0;
            rsp_rdat2    <= '0;
            rsp_err      <= 1'b0;
            rf_reg1      <= '0;
            rf_reg2      <= '0;
            rf_reg3      <= '0;
            rf_wdat      <= '0;
            rf_reg_dest  <= 1'b0;
            rf_reg_write <= 1'b0;
        end else begin
            ack     <= '0;
            rsp_err <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    grant  <= pick;
                    g_we   <= req_we[pick];
                    g_ra   <= pick ? req_ra[2*ADDR_W-1:ADDR_W] : req_ra[ADDR_W-1:0];
                    g_rb   <= pick ? req_rb[2*ADDR_W-1:ADDR_W] : req_rb[ADDR_W-1:0];
                    g_wa   <= pick ? req_wa[2*ADDR_W-1:ADDR_W] : req_wa[ADDR_W-1:0];
                    g_wdat <= pick ? req_wdat[2*DATA_W-1:DATA_W] : req_wdat[DATA_W-1:0];
                    state  <= SETUP;
                end
                SETUP: if (g_we) begin
                    rf_reg3     <= g_wa;
                    rf_reg2     <= '0;
                    rf_wdat     <= g_wdat;
                    rf_reg_dest <= 1'b1;
                    state       <= WSTROBE;
                end else begin
                    rf_reg1     <= g_ra;
                    rf_reg2     <= g_rb;
                    rf_reg_dest <= 1'b0;
                    state       <= CAPT;
                end
                // addresses have been stable for a full cycle before the strobe rises
                WSTROBE: begin
                    rf_reg_write <= !r0_block;
                    err          <= r0_block;
                    state        <= DONE;
                end
                CAPT: begin
                    rsp_rdat1 <= rf_rdat1;
                    rsp_rdat2 <= rf_rdat2;
                    state     <= DONE;
                end
                DONE: begin
                    ack[grant]   <= 1'b1;
                    rsp_err      <= err;
                    last_grant   <= grant;
                    err          <= 1'b0;
                    rf_reg_write <= 1'b0;
                    rf_reg_dest  <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: randomized scenarios checked against a transaction-level model of the shared register file.
module tb_regfile_access_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  req = '0, req_we = '0;
    logic [9:0]  req_ra = '0, req_rb = '0, req_wa = '0;
    logic [63:0] req_wdat = '0;
    logic [1:0]  ack;
    logic [31:0] rsp_rdat1, rsp_rdat2, rf_wdat, rf_rdat1, rf_rdat2;
    logic        rsp_err, busy, rf_reg_dest, rf_reg_write;
    logic [4:0]  rf_reg1, rf_reg2, rf_reg3;

    regfile_access_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_ra(req_ra), .req_rb(req_rb),
        .req_wa(req_wa), .req_wdat(req_wdat), .ack(ack), .rsp_rdat1(rsp_rdat1), .rsp_rdat2(rsp_rdat2),
        .rsp_err(rsp_err), .busy(busy), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_reg3(rf_reg3),
        .rf_wdat(rf_wdat), .rf_reg_dest(rf_reg_dest), .rf_reg_write(rf_reg_write),
        .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2)
    );

    always #5 clk = ~clk;

    // the register file the arbiter controls: async read, write on the strobe
    logic [31:0] rf [32] = '{default: 32'h0};
    assign rf_rdat1 = rf[rf_reg1];
    assign rf_rdat2 = rf[rf_reg2];
    always @(posedge clk) if (rf_reg_write && rf_reg_dest) rf[rf_reg3] <= rf_wdat;

    // transaction-level expectations
    logic [31:0] ref_rf [32] = '{default: 32'h0};
    logic        last_model = 1'b1;
    logic [31:0] exp_d1 = '0, exp_d2 = '0;
    int          n_cmp = 0, n_bad = 0;

    logic [1:0]  a_seen;
    logic        e_seen, stb_dest;
    int          cyc, nstb;
    logic [4:0]  stb_addr;
    logic [31:0] stb_wdat;

    function automatic logic winner(input logic [1:0] r);
        return (r == 2'b11) ? ~last_model : r[1];
    endfunction

    task automatic set_fields(input int r, input logic we, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [4:0] wa, input logic [31:0] wd);
        req_we[r] = we;
        req_ra[r*5 +: 5] = ra;
        req_rb[r*5 +: 5] = rb;
        req_wa[r*5 +: 5] = wa;
        req_wdat[r*32 +: 32] = wd;
    endtask

    // presents req at a falling edge, watches strobes, returns at the falling edge that shows ack
    task automatic run_txn(input logic [1:0] r, input bit drop);
        a_seen = '0; e_seen = 1'b0; cyc = 0; nstb = 0; stb_addr = '0; stb_dest = 1'b0; stb_wdat = '0;
        req = r;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            cyc = c;
            if (rf_reg_write) begin nstb++; stb_addr = rf_reg3; stb_dest = rf_reg_dest; stb_wdat = rf_wdat; end
            if (drop && c == 1) begin
                req = '0; req_we = 2'($urandom); req_ra = 10'($urandom); req_rb = 10'($urandom);
                req_wa = 10'($urandom); req_wdat = {$urandom, $urandom};
            end
            if (ack != '0) begin a_seen = ack; e_seen = rsp_err; req = '0; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if ({ack, rsp_err, busy, rf_reg_dest, rf_reg_write} !== 6'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 000000", {ack, rsp_err, busy, rf_reg_dest, rf_reg_write}); end
        n_cmp++; if ({rf_reg1, rf_reg2, rf_reg3, rf_wdat, rsp_rdat1, rsp_rdat2} !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {rf_reg1, rf_reg2, rf_reg3, rf_wdat, rsp_rdat1, rsp_rdat2}); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ack, busy, rf_reg_write} !== 4'b0) begin n_bad++; $display("FAIL reset_idle: got %b want 0000", {ack, busy, rf_reg_write}); end
    endtask

    task automatic test_write();
        set_fields(0, 1'b1, 5'd0, 5'd0, 5'd8, 32'hDEADBEEF);
        run_txn(2'b01, 1'b0);
        n_cmp++; if (a_seen !== 2'b01) begin n_bad++; $display("FAIL write_ack: got %b want 01", a_seen); end
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL write_latency: got %0d want 4", cyc); end
        n_cmp++; if (nstb !== 1) begin n_bad++; $display("FAIL write_strobe_count: got %0d want 1", nstb); end
        n_cmp++; if ({stb_dest, stb_addr} !== {1'b1, 5'd8}) begin n_bad++; $display("FAIL write_strobe_addr: got %b/%0d want 1/8", stb_dest, stb_addr); end
        n_cmp++; if (stb_wdat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_strobe_data: got %h want deadbeef", stb_wdat); end
        n_cmp++; if (e_seen !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b want 0", e_seen); end
        ref_rf[8] = 32'hDEADBEEF; last_model = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ack, busy, rf_reg_write} !== 4'b0) begin n_bad++; $display("FAIL write_ack_pulse: got %b want 0000", {ack, busy, rf_reg_write}); end
    endtask

    task automatic test_read();
        set_fields(1, 1'b0, 5'd8, 5'd9, 5'd0, 32'h0);
        run_txn(2'b10, 1'b0);
        n_cmp++; if (a_seen !== 2'b10) begin n_bad++; $display("FAIL read_ack: got %b want 10", a_seen); end
        n_cmp++; if (rsp_rdat1 !== ref_rf[8]) begin n_bad++; $display("FAIL read_d1: got %h want %h", rsp_rdat1, ref_rf[8]); end
        n_cmp++; if (rsp_rdat2 !== ref_rf[9]) begin n_bad++; $display("FAIL read_d2: got %h want %h", rsp_rdat2, ref_rf[9]); end
        n_cmp++; if (nstb !== 0) begin n_bad++; $display("FAIL read_strobe: got %0d want 0", nstb); end
        exp_d1 = ref_rf[8]; exp_d2 = ref_rf[9]; last_model = 1'b1;
    endtask

    task automatic test_random();
        logic        we_v [2];
        logic [4:0]  ra_v [2], rb_v [2], wa_v [2];
        logic [31:0] wd_v [2];
        logic [1:0]  r;
        logic        w;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 2; i++) begin
                we_v[i] = 1'($urandom); ra_v[i] = 5'($urandom); rb_v[i] = 5'($urandom);
                wa_v[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); wd_v[i] = $urandom;
                set_fields(i, we_v[i], ra_v[i], rb_v[i], wa_v[i], wd_v[i]);
            end
            r = 2'($urandom_range(1, 3));
            w = winner(r);
            run_txn(r, 1'b0);
            n_cmp++; if (a_seen !== (w ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rand_ack[%0d]: got %b want %b", t, a_seen, w ? 2'b10 : 2'b01); end
            n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want 4", t, cyc); end
            if (we_v[w]) begin
                n_cmp++; if (nstb !== ((wa_v[w] != 0) ? 1 : 0)) begin n_bad++; $display("FAIL rand_strobe[%0d]: got %0d wa %0d", t, nstb, wa_v[w]); end
                n_cmp++; if (e_seen !== (wa_v[w] == 0)) begin n_bad++; $display("FAIL rand_err[%0d]: got %b wa %0d", t, e_seen, wa_v[w]); end
                if (nstb == 1) begin
                    n_cmp++; if ({stb_addr, stb_wdat} !== {wa_v[w], wd_v[w]}) begin n_bad++; $display("FAIL rand_wr_fields[%0d]: got %0d/%h want %0d/%h", t, stb_addr, stb_wdat, wa_v[w], wd_v[w]); end
                end
                if (wa_v[w] != 0) ref_rf[wa_v[w]] = wd_v[w];
            end else begin
                n_cmp++; if (nstb !== 0 || e_seen !== 1'b0) begin n_bad++; $display("FAIL rand_rd_side[%0d]: strobes %0d err %b want 0 0", t, nstb, e_seen); end
                exp_d1 = ref_rf[ra_v[w]]; exp_d2 = ref_rf[rb_v[w]];
            end
            n_cmp++; if ({rsp_rdat1, rsp_rdat2} !== {exp_d1, exp_d2}) begin n_bad++; $display("FAIL rand_rdat[%0d]: got %h/%h want %h/%h", t, rsp_rdat1, rsp_rdat2, exp_d1, exp_d2); end
            last_model = w;
        end
    endtask

    task automatic test_alternate();
        logic [4:0] ra_v [2], rb_v [2];
        logic       w;
        int         got = 0, prev = 0, stb = 0;
        for (int i = 0; i < 2; i++) begin
            ra_v[i] = 5'($urandom); rb_v[i] = 5'($urandom);
            set_fields(i, 1'b0, ra_v[i], rb_v[i], 5'($urandom), $urandom);
        end
        req = 2'b11;
        for (int c = 1; c <= 40 && got < 4; c++) begin
            @(negedge clk);
            if (rf_reg_write) stb++;
            if (ack != '0) begin
                w = ~last_model;
                n_cmp++; if (ack !== (w ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL alt_ack[%0d]: got %b want %b", got, ack, w ? 2'b10 : 2'b01); end
                n_cmp++; if ({rsp_rdat1, rsp_rdat2} !== {ref_rf[ra_v[w]], ref_rf[rb_v[w]]}) begin n_bad++; $display("FAIL alt_rdat[%0d]: got %h/%h want %h/%h", got, rsp_rdat1, rsp_rdat2, ref_rf[ra_v[w]], ref_rf[rb_v[w]]); end
                if (got > 0) begin
                    n_cmp++; if (c - prev !== 4) begin n_bad++; $display("FAIL alt_spacing[%0d]: got %0d want 4", got, c - prev); end
                end
                exp_d1 = ref_rf[ra_v[w]]; exp_d2 = ref_rf[rb_v[w]];
                prev = c; last_model = w; got++;
                if (got == 4) req = '0;
            end
        end
        req = '0;
        n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL alt_count: got %0d want 4", got); end
        n_cmp++; if (stb !== 0) begin n_bad++; $display("FAIL alt_no_write: got %0d want 0", stb); end
    endtask

    task automatic test_r0_protect();
        set_fields(0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
        run_txn(2'b01, 1'b0);
        n_cmp++; if (a_seen !== 2'b01) begin n_bad++; $display("FAIL r0_ack: got %b want 01", a_seen); end
        n_cmp++; if (nstb !== 0) begin n_bad++; $display("FAIL r0_strobe: got %0d want 0", nstb); end
        n_cmp++; if (e_seen !== 1'b1) begin n_bad++; $display("FAIL r0_err: got %b want 1", e_seen); end
        last_model = 1'b0;
        set_fields(1, 1'b0, 5'd0, 5'd8, 5'd0, 32'h0);
        run_txn(2'b10, 1'b0);
        n_cmp++; if (rsp_rdat1 !== ref_rf[0]) begin n_bad++; $display("FAIL r0_readback: got %h want %h", rsp_rdat1, ref_rf[0]); end
        n_cmp++; if (e_seen !== 1'b0) begin n_bad++; $display("FAIL r0_err_cleared: got %b want 0", e_seen); end
        exp_d1 = ref_rf[0]; exp_d2 = ref_rf[8]; last_model = 1'b1;
    endtask

    task automatic test_reset_midop();
        logic [31:0] v = $urandom;
        int          late = 0;
        set_fields(0, 1'b1, 5'd0, 5'd0, 5'd16, v);
        run_txn(2'b01, 1'b0);
        n_cmp++; if (a_seen !== 2'b01) begin n_bad++; $display("FAIL mid_prewrite_ack: got %b want 01", a_seen); end
        ref_rf[16] = v; last_model = 1'b0;
        set_fields(0, 1'b1, 5'd0, 5'd0, 5'd16, ~v);
        req = 2'b01;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if ({ack, rsp_err, busy, rf_reg_dest, rf_reg_write} !== 6'b0) begin n_bad++; $display("FAIL mid_reset_ctl: got %b want 000000", {ack, rsp_err, busy, rf_reg_dest, rf_reg_write}); end
        n_cmp++; if ({rf_reg1, rf_reg2, rf_reg3, rf_wdat, rsp_rdat1, rsp_rdat2} !== '0) begin n_bad++; $display("FAIL mid_reset_data: got %h want 0", {rf_reg1, rf_reg2, rf_reg3, rf_wdat, rsp_rdat1, rsp_rdat2}); end
        req = '0;
        @(negedge clk);
        reset = 1'b0; last_model = 1'b1; exp_d1 = '0; exp_d2 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack != '0 || rf_reg_write) late++;
        end
        n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL mid_no_ack: got %0d events want 0", late); end
        set_fields(1, 1'b0, 5'd16, 5'd8, 5'd0, 32'h0);
        run_txn(2'b10, 1'b0);
        n_cmp++; if ({a_seen, rsp_rdat1} !== {2'b10, ref_rf[16]}) begin n_bad++; $display("FAIL mid_r16_kept: got %b/%h want 10/%h", a_seen, rsp_rdat1, ref_rf[16]); end
        exp_d1 = ref_rf[16]; exp_d2 = ref_rf[8]; last_model = 1'b1;
    endtask

    task automatic test_drop_req();
        logic [31:0] v = $urandom;
        set_fields(1, 1'b1, 5'd0, 5'd0, 5'd10, v);
        run_txn(2'b10, 1'b0);
        ref_rf[10] = v; last_model = 1'b1;
        set_fields(0, 1'b0, 5'd10, 5'd16, 5'd0, 32'h0);
        run_txn(2'b01, 1'b1);
        n_cmp++; if (a_seen !== 2'b01) begin n_bad++; $display("FAIL drop_ack: got %b want 01", a_seen); end
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL drop_latency: got %0d want 4", cyc); end
        n_cmp++; if ({rsp_rdat1, rsp_rdat2} !== {ref_rf[10], ref_rf[16]}) begin n_bad++; $display("FAIL drop_rdat: got %h/%h want %h/%h", rsp_rdat1, rsp_rdat2, ref_rf[10], ref_rf[16]); end
        n_cmp++; if (nstb !== 0) begin n_bad++; $display("FAIL drop_strobe: got %0d want 0", nstb); end
        last_model = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_alternate();
        test_r0_protect();
        test_reset_midop();
        test_drop_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
